apb_master_port: RTL

- Single-outstanding APB initiator that converts a valid/ready command stream into APB SETUP/ACCESS transfers and returns a response.
- It is the bus-side counterpart of the peripheral APB slave register front-ends, such as the I2C and UART register blocks.
- Used by the debug/bring-up path and block-level benches to program peripheral register files over APB without a CPU.
- Adds wait-state handling, slave-error capture and an access timeout.

---
 rtl/apb_master_port_if.sv | 30 +++
 rtl/apb_master_port.sv | 120 ++++++++++++
 2 files changed

// File: rtl/apb_master_port_if.sv
// apb_master_port_if
//   APB bus bundle between an initiator (apb_master_port) and a peripheral.
//   Parameters: ADDR_W (PADDR width), DATA_W (PWDATA/PRDATA width).
//   Signals:
//     PSEL, PENABLE, PWRITE, PADDR, PWDATA  driven by the master
//     PRDATA, PREADY, PSLVERR               driven by the slave
//   Modports: master (initiator side), slave (peripheral side).
interface apb_master_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_port.sv
// apb_master_port
//   Single-outstanding APB initiator. Turns one valid/ready command into an
//   APB SETUP + ACCESS transfer and returns a held valid/ready response.
//   Handles wait states, captures PSLVERR and aborts an ACCESS phase that
//   stays not-ready for TIMEOUT cycles (TIMEOUT = 0 waits forever).
//   Ports:
//     clk, n_rst               clock, asynchronous active-low reset
//     req_valid/req_ready      command handshake (req_ready = idle)
//     req_write/addr/wdata     command payload
//     rsp_valid/rsp_ready      response handshake, held until accepted
//     rsp_rdata/err/timeout    response payload (rdata is 0 for writes/aborts)
//     apb                      APB bus, master modport
module apb_master_port #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  apb_master_port_if.master    apb
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // Counter only has to reach TIMEOUT-1; at least one bit wide so the
  // TIMEOUT = 0 configuration still elaborates.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  logic [1:0]        state_reg;
  logic [CNT_W-1:0]  wait_cnt_reg;
  logic              pwrite_reg;
  logic [ADDR_W-1:0] paddr_reg;
  logic [DATA_W-1:0] pwdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;
  logic              timeout_reg;

  // Handshake and bus strobes are pure decodes of the state register, so
  // they drop together with the asynchronous reset and req_ready has no
  // path from req_valid.
  assign req_ready   = (state_reg == IDLE);
  assign rsp_valid   = (state_reg == RESP);
  assign apb.PSEL    = (state_reg == SETUP) || (state_reg == ACCESS);
  assign apb.PENABLE = (state_reg == ACCESS);
  assign apb.PWRITE  = pwrite_reg;
  assign apb.PADDR   = paddr_reg;
  assign apb.PWDATA  = pwdata_reg;

  assign rsp_rdata   = rdata_reg;
  assign rsp_err     = err_reg;
  assign rsp_timeout = timeout_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      pwrite_reg   <= 1'b0;
      paddr_reg    <= '0;
      pwdata_reg   <= '0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            paddr_reg   <= req_addr;
            pwdata_reg  <= req_wdata;
            pwrite_reg  <= req_write;
            err_reg     <= 1'b0;
            timeout_reg <= 1'b0;
            state_reg   <= SETUP;
          end
        end
        SETUP: begin
          wait_cnt_reg <= '0;
          state_reg    <= ACCESS;
        end
        ACCESS: begin
          // PREADY is checked first so a completion on the last allowed
          // cycle beats the timeout. PSLVERR only matters with PREADY high.
          if (apb.PREADY) begin
            rdata_reg <= pwrite_reg ? '0 : apb.PRDATA;
            err_reg   <= apb.PSLVERR;
            state_reg <= RESP;
          end else if (TIMEOUT_EN && (wait_cnt_reg == CNT_LAST)) begin
            rdata_reg   <= '0;
            err_reg     <= 1'b1;
            timeout_reg <= 1'b1;
            state_reg   <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
